// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial ripple-carry adder.
package rca_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   localparam int DEF_SLICE = 4;
   localparam int DEF_WIDTH = 16;

   // Number of slice passes needed to cover the full operand.
   function automatic int calc_nslice(input int width, input int slice);
      return width / slice;
   endfunction

   // Width of the slice index counter; never narrower than one bit.
   function automatic int calc_idx_w(input int width, input int slice);
      int n;
      n = width / slice;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rca_slice.sv
// SLICE-bit combinational ripple-carry adder built from full-adder cells.

// Single-bit full adder cell.
module rca_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice
   import rca_seq_pkg::*;
#(
   parameter int SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);
   logic [SLICE:0] c;

   assign c[0] = cin;

   // One cell per bit, carry chained LSB to MSB.
   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      rca_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[SLICE];
endmodule

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle adder: one SLICE-bit ripple slice reused LSB-first across
// NSLICE cycles, with a registered carry between passes.
module rca_nibble_sequencer
   import rca_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NSLICE = calc_nslice(WIDTH, SLICE);
   localparam int IW     = calc_idx_w(WIDTH, SLICE);

   seq_state_t       state, state_nxt;
   logic [IW-1:0]    slice_idx;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             cout_q, ovf_q;

   logic [SLICE-1:0] sl_s;
   logic             sl_co;
   logic             accept, xfer, last;
   int               base;

   always_comb base = int'(slice_idx) * SLICE;

   assign last   = (slice_idx == IW'(NSLICE - 1));
   assign accept = in_valid & in_ready;
   assign xfer   = out_valid & out_ready;

   rca_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_q[base +: SLICE]),
      .b    (b_q[base +: SLICE]),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: DONE can chain straight into RUN when a new operand
   // pair is accepted on the same edge the result is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last)   state_nxt = DONE;
         DONE:    if (xfer)   state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         RUN:  busy     = 1'b1;
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: capture on accept, one slice per RUN cycle, flags on the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slice_idx <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         a_q       <= a;
         b_q       <= b;
         carry_q   <= cin;
         slice_idx <= '0;
      end else if (state == RUN) begin
         sum_q[base +: SLICE] <= sl_s;
         carry_q              <= sl_co;
         slice_idx            <= slice_idx + IW'(1);
         if (last) begin
            cout_q <= sl_co;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                      (sl_s[SLICE-1] != a_q[WIDTH-1]);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: doc/rca_nibble_sequencer.md
Name: rca_nibble_sequencer

Overview:
- Multi-cycle WIDTH-bit adder that time-multiplexes one SLICE-bit ripple-carry slice across NSLICE = WIDTH/SLICE cycles, least-significant slice first.
- A registered carry links consecutive slices.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width ripple adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits added per cycle (slice adder width).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b/cin valid
- in_ready  out  1  sequencer can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  carry-out of MSB
- ovf  out  1  signed overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Reset and async assert of rst_n:
  - state=IDLE, slice_idx=0, carry_q=0.
  - Operand regs=0, sum=0, cout=0, ovf=0.
  - out_valid=0, busy=0.
- in_ready is combinational: 1 in IDLE, out_ready in DONE, 0 in RUN.
- Accept occurs at a clock edge with in_valid & in_ready:
  - Capture a, b → a_q, b_q; cin → carry_q.
  - slice_idx ← 0; state ← RUN.
- RUN, each cycle:
  - Slice adds a_q[idx], b_q[idx] and carry_q, where [idx] selects bits idx*SLICE +: SLICE.
  - sum[idx] ← slice sum; carry_q ← slice carry.
  - idx ← idx+1.
  - When idx==NSLICE-1, state ← DONE instead, and on that edge:
    - cout ← slice carry.
    - ovf ← (a_q[MSB]==b_q[MSB]) & (slice sum MSB != a_q[MSB]).
- DONE: out_valid=1. sum/cout/ovf are held stable until the transfer completes (out_valid & out_ready).
  - Transfer with no accept on the same edge: state ← IDLE.
  - Transfer with in_valid=1 on the same edge: new operands are captured and state ← RUN. Back-to-back throughput is one result per NSLICE+1 cycles.
- Latency: out_valid rises exactly NSLICE edges after the accept edge (4 with defaults).
- sum bits not yet written in RUN keep their previous value. Consumers must only sample sum when out_valid=1.
- Input changes during RUN/DONE are ignored: operands are used only from registers.
- Wrap-around: the sum is modulo 2^WIDTH; the carry out of the MSB appears only on cout.
- out_ready without out_valid: no effect. in_valid in RUN: no effect, stalled by in_ready=0.
- Reset mid-RUN or mid-DONE: the operation is aborted with no output. After rst_n release the block is in IDLE with in_ready=1.

Decomposition:
- Shared package rca_seq_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default constants SLICE=4 and WIDTH=16.
  - Function computing NSLICE and the idx width as $clog2(NSLICE), min 1.
- Sub-module rca_slice: purely combinational SLICE-bit ripple-carry adder built from the team's full-adder cell. Ports: a, b, cin, s, cout.
- The sequencer contains one instance of rca_slice and all sequential logic.

Test Plan:
- Basic add: a=0xAAAA, b=0x5555, cin=0 → after 4 cycles out_valid=1, sum=0xFFFF, cout=0, ovf=0.
- Carry ripple across slices:
  - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
  - a=0xEDCB, b=0x1234, cin=1 → sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure and input hold: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid, sum, cout and ovf stay stable; in_ready=0 throughout.
  - Change a/b during RUN → result unaffected.
- Back-to-back: in_valid held high with out_ready=1 and operand pairs (1,2), (3,4), (0x00FF,0x0001).
  - Results 0x0003, 0x0007, 0x0100 appear, each 5 cycles apart.
  - The second accept coincides with the first result transfer.
- Reset mid-RUN: assert rst_n=0 asynchronously at RUN cycle 2.
  - All outputs clear immediately: out_valid=0, busy=0, sum=0.
  - After release in_ready=1, and a new add 0x0010+0x0020 returns 0x0030.
